// File: rtl/dma_arbiter_if.sv
// Bundle of requester-side and DMA-engine-side signals for the DMA arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface dma_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [7*NREQ-1:0]    req_addr;
    logic [18*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_done;
    logic [17:0]          dma_dat_w;
    logic [6:0]           dma_dat_addr;
    logic                 we;
    logic                 dma_busy;
    logic                 active;
    logic                 err;

    modport master (
        input  req_valid, req_addr, req_data, dma_busy,
        output req_ready, req_done, dma_dat_w, dma_dat_addr, we, active, err
    );

    modport slave (
        output req_valid, req_addr, req_data, dma_busy,
        input  req_ready, req_done, dma_dat_w, dma_dat_addr, we, active, err
    );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters a single-beat write
// into a shared DMA engine, with a busy-acknowledge timeout and sticky error.
module dma_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          resetn,
    dma_arbiter_if.master bus
);
    localparam int              IW          = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0    = NREQ'(1);
    localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IW-1:0]   rr_ptr_r;
    logic [IW-1:0]   owner_r;
    logic [IW-1:0]   winner_s;
    logic [IW-1:0]   idx_s;
    logic            grant_s;
    logic            timeout_s;
    logic            finish_s;
    logic [7:0]      cnt_r;
    logic [17:0]     dat_r;
    logic [6:0]      addr_r;
    logic            we_r;
    logic            active_r;
    logic            err_r;
    logic [NREQ-1:0] done_r;

    // First valid requester at or after rr_ptr; scanning downwards lets the nearest one win.
    always_comb begin
        winner_s = '0;
        idx_s    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s    = IW'((int'(rr_ptr_r) + k) % NREQ);
            winner_s = bus.req_valid[idx_s] ? idx_s : winner_s;
        end
    end

    // A grant also waits out the req_done cycle so transfers never overlap.
    assign grant_s = resetn && (state_r == IDLE) && !bus.dma_busy &&
                     (done_r == '0) && (|bus.req_valid);

    // Next-state logic and completion events.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) state_s = ISSUE;
                else         state_s = IDLE;
            end
            ISSUE: state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.dma_busy) begin
                    state_s = WAIT_DONE;
                end else if (cnt_r == TIMEOUT_CNT) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!bus.dma_busy) begin
                    state_s  = IDLE;
                    finish_s = 1'b1;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, timeout counter and registered strobes/flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            we_r     <= 1'b0;
            active_r <= 1'b0;
            err_r    <= 1'b0;
            done_r   <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= (state_r == WAIT_BUSY) ? cnt_r + 8'd1 : 8'd0;
            we_r     <= (state_s == ISSUE);
            active_r <= (state_s != IDLE);
            err_r    <= err_r | timeout_s;
            done_r   <= (timeout_s || finish_s) ? (ONE_HOT0 << owner_r) : '0;
        end
    end

    // Winner capture: owner, rotating pointer and the outgoing address/data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_r <= '0;
            owner_r  <= '0;
            addr_r   <= 7'd0;
            dat_r    <= 18'd0;
        end else if (grant_s) begin
            owner_r  <= winner_s;
            rr_ptr_r <= (int'(winner_s) == NREQ - 1) ? '0 : winner_s + IW'(1);
            addr_r   <= bus.req_addr[7*int'(winner_s) +: 7];
            dat_r    <= bus.req_data[18*int'(winner_s) +: 18];
        end
    end

    assign bus.req_ready    = grant_s ? (ONE_HOT0 << winner_s) : '0;
    assign bus.req_done     = done_r;
    assign bus.dma_dat_w    = dat_r;
    assign bus.dma_dat_addr = addr_r;
    assign bus.we           = we_r;
    assign bus.active       = active_r;
    assign bus.err          = err_r;

endmodule

// File: tb/tb_dma_arbiter.sv
// Randomized bench for dma_arbiter: the bench plays requesters and DMA engine
// and predicts every output from a transaction timeline (grant, issue, done).
module tb_dma_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dma_arbiter_if #(.NREQ(NREQ)) bus ();

    dma_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;

    // Timeline model: cycle numbers of the current transaction's events.
    int          ptr, owner, g, b, len, done_cycle, free_cycle, err_cycle;
    bit          err_m, force_busy;
    logic [6:0]  exp_addr;
    logic [17:0] exp_data;

    bit          pend  [NREQ];
    logic [6:0]  raddr [NREQ];
    logic [17:0] rdata [NREQ];
    int          req_pct, withdraw_pct, fix_mode, fix_d, fix_l;
    bit          keep_all;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        ptr = 0; owner = 0; g = -100; b = -1; len = 0;
        done_cycle = -100; free_cycle = 0; err_cycle = -1;
        err_m = 1'b0; exp_addr = 7'd0; exp_data = 18'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check_eq({tag, "_done"},  32'(bus.req_done), 32'd0);
        check_eq({tag, "_we"},    32'(bus.we), 32'd0);
        check_eq({tag, "_active"},32'(bus.active), 32'd0);
        check_eq({tag, "_err"},   32'(bus.err), 32'd0);
        check_eq({tag, "_addr"},  32'(bus.dma_dat_addr), 32'd0);
        check_eq({tag, "_data"},  32'(bus.dma_dat_w), 32'd0);
    endtask

    task automatic run_cycle();
        logic            busy;
        logic [NREQ-1:0] exp_rdy, exp_done;
        int              win, mode, d, l;
        @(negedge clk);
        n++;
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && (keep_all || int'($urandom_range(99)) < req_pct)) begin
                pend[i]  = 1'b1;
                raddr[i] = 7'($urandom);
                rdata[i] = 18'($urandom);
            end else if (pend[i] && int'($urandom_range(99)) < withdraw_pct) begin
                pend[i] = 1'b0;
            end
        end
        busy = force_busy || (b >= 0 && n >= b && n < b + len);
        bus.dma_busy = busy;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]        = pend[i];
            bus.req_addr[7*i +: 7]   = raddr[i];
            bus.req_data[18*i +: 18] = rdata[i];
        end
        #1;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && pend[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
        end
        exp_rdy = '0;
        if (n >= free_cycle && !busy && win >= 0) exp_rdy[win] = 1'b1;
        exp_done = '0;
        if (n == done_cycle) exp_done[owner] = 1'b1;
        if (n == err_cycle) err_m = 1'b1;
        check_eq("ready",  32'(bus.req_ready), 32'(exp_rdy));
        check_eq("done",   32'(bus.req_done), 32'(exp_done));
        check_eq("we",     32'(bus.we), 32'(n == g + 1));
        check_eq("active", 32'(bus.active), 32'(n > g && n < done_cycle));
        check_eq("err",    32'(bus.err), 32'(err_m));
        check_eq("addr",   32'(bus.dma_dat_addr), 32'(exp_addr));
        check_eq("data",   32'(bus.dma_dat_w), 32'(exp_data));
        if (exp_rdy != '0) begin
            g        = n;
            owner    = win;
            ptr      = (win + 1) % NREQ;
            exp_addr = raddr[win];
            exp_data = rdata[win];
            pend[win] = 1'b0;
            mode = (fix_mode >= 0) ? fix_mode : (($urandom_range(4) == 0) ? 0 : 1);
            if (mode == 0) begin
                b = -1; len = 0;
                done_cycle = g + TIMEOUT + 1;
                err_cycle  = done_cycle;
            end else begin
                d = (fix_mode >= 0) ? fix_d : int'($urandom_range(TIMEOUT - 2));
                l = (fix_mode >= 0) ? fix_l : int'($urandom_range(5, 1));
                b = g + 2 + d; len = l;
                done_cycle = b + l + 1;
            end
            free_cycle = done_cycle + 1;
        end
    endtask

    initial begin
        model_reset();
        force_busy = 1'b0; keep_all = 1'b0; req_pct = 0; withdraw_pct = 0;
        fix_mode = 1; fix_d = 0; fix_l = 1;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; raddr[i] = 7'd0; rdata[i] = 18'd0;
        end
        resetn = 1'b0;
        bus.req_valid = '1; bus.req_addr = '0; bus.req_data = '0; bus.dma_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        bus.req_valid = '0;
        resetn = 1'b1;

        // All requesters continuously valid: grants rotate 0,1,2,3,0,...
        keep_all = 1'b1;
        repeat (40) run_cycle();
        keep_all = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (12) run_cycle();

        // Single request from requester 2 with boundary data.
        pend[2] = 1'b1; raddr[2] = 7'h15; rdata[2] = 18'h3FFFF;
        fix_d = 1; fix_l = 3;
        repeat (12) run_cycle();

        // Engine never acknowledges: timeout, then a normal transfer still works.
        fix_mode = 0; pend[1] = 1'b1;
        repeat (TIMEOUT + 4) run_cycle();
        fix_mode = 1; pend[0] = 1'b1;
        repeat (12) run_cycle();

        // Engine busy while idle: request 1 waits until busy drops.
        force_busy = 1'b1; pend[1] = 1'b1;
        repeat (6) run_cycle();
        force_busy = 1'b0;
        repeat (12) run_cycle();

        // Requester 3 pulses valid only while the engine is busy.
        fix_d = 0; fix_l = 4; pend[0] = 1'b1;
        repeat (3) run_cycle();
        pend[3] = 1'b1;
        repeat (2) run_cycle();
        pend[3] = 1'b0;
        repeat (8) run_cycle();
        pend[2] = 1'b1;
        repeat (10) run_cycle();

        // Reset while waiting for the engine to finish.
        fix_d = 0; fix_l = 8; pend[2] = 1'b1;
        repeat (6) run_cycle();
        force_busy = 1'b1; bus.dma_busy = 1'b1;
        pend[1] = 1'b1; bus.req_valid[1] = 1'b1;
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) run_cycle();
        force_busy = 1'b0;
        repeat (12) run_cycle();

        // Randomized traffic with random engine behaviour and withdrawals.
        fix_mode = -1; req_pct = 30; withdraw_pct = 3;
        repeat (3000) run_cycle();
        req_pct = 0; withdraw_pct = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (20) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
